// File: rtl/byte_tx.sv
// Serializer: captures a WIDTH-bit word on the load edge, presents it on `out` one bit per
// enabled TCK edge, then raises `done`. Define BYTE_TX_MSB_FIRST_EN for MSB-first bit order.
module byte_tx #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_tck,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [CntW-1:0]    cnt_q;

    logic               first_bit;
    logic               next_bit;
    logic [WIDTH-1:0]   shift_next;

    // The captured word is shifted so the next bit to present always sits next to the output end.
    always_comb begin
`ifdef BYTE_TX_MSB_FIRST_EN
        first_bit  = in[WIDTH-1];
        next_bit   = shift_q[WIDTH-2];
        shift_next = shift_q << 1;
`else
        first_bit  = in[0];
        next_bit   = shift_q[1];
        shift_next = shift_q >> 1;
`endif
    end

    always_ff @(posedge clk_tck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            out     <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        shift_q <= in;
                        out     <= first_bit;
                        cnt_q   <= CntOne;
                        state_q <= StShift;
                    end else begin
                        out <= 1'b0;
                    end
                end
                StShift: begin
                    if (enable) begin
                        if (cnt_q < CntLast) begin
                            out     <= next_bit;
                            shift_q <= shift_next;
                            cnt_q   <= cnt_q + CntOne;
                        end else begin
                            out     <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    out  <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    out     <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_tx.sv
// Bench for byte_tx: directed IDCODE/pause/restart cases plus randomized transfers, all checked
// every cycle against a count-of-enabled-edges model.
module tb_byte_tx;

    localparam int unsigned WIDTH = 32;

    logic             clk_tck = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable  = 1'b0;
    logic [WIDTH-1:0] in_w    = '0;
    logic             out_w;
    logic             done_w;

    byte_tx #(.WIDTH(WIDTH)) dut (
        .clk_tck (clk_tck),
        .reset_n (reset_n),
        .enable  (enable),
        .in      (in_w),
        .out     (out_w),
        .done    (done_w)
    );

    always #5 clk_tck = ~clk_tck;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a transfer is just the captured word plus the number of enabled edges since load.
    logic             m_loaded;
    logic [WIDTH-1:0] m_word;
    int               m_n;

    always @(posedge clk_tck or negedge reset_n) begin
        if (!reset_n) begin
            m_loaded <= 1'b0;
            m_word   <= '0;
            m_n      <= 0;
        end else if (enable) begin
            if (!m_loaded) begin
                m_loaded <= 1'b1;
                m_word   <= in_w;
                m_n      <= 1;
            end else if (m_n <= WIDTH) begin
                m_n <= m_n + 1;
            end
        end
    end

    function automatic int bit_idx(input int k);
`ifdef BYTE_TX_MSB_FIRST_EN
        return WIDTH - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic model_out();
        logic [WIDTH-1:0] t;
        if (m_loaded && m_n <= WIDTH) begin
            t = m_word >> bit_idx(m_n - 1);
            return t[0];
        end
        return 1'b0;
    endfunction

    function automatic logic model_done();
        return m_loaded && (m_n > WIDTH);
    endfunction

    always @(negedge clk_tck) begin
        if (chk_en) begin
            check("cyc_out", {31'b0, out_w}, {31'b0, model_out()});
            check("cyc_done", {31'b0, done_w}, {31'b0, model_done()});
        end
    end

    task automatic tick();
        @(posedge clk_tck);
        #2;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        enable  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    int idbits[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        int exp_bit;

        repeat (2) tick();
        check("reset_out", {31'b0, out_w}, 32'd0);
        check("reset_done", {31'b0, done_w}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // IDCODE shift, enable continuous
        in_w   = 32'h000FAF01;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) begin
`ifdef BYTE_TX_MSB_FIRST_EN
            exp_bit = (k >= 12) ? idbits[31 - k] : 0;
`else
            exp_bit = (k < 20) ? idbits[k] : 0;
`endif
            check($sformatf("idcode_bit%0d", k), {31'b0, out_w}, 32'(exp_bit));
            check("idcode_done_low", {31'b0, done_w}, 32'd0);
            tick();
        end
        check("idcode_done", {31'b0, done_w}, 32'd1);
        check("idcode_out_after", {31'b0, out_w}, 32'd0);

        // enable toggling while DONE
        for (int i = 0; i < 4; i++) begin
            enable = ~enable;
            tick();
            check("done_hold_done", {31'b0, done_w}, 32'd1);
            check("done_hold_out", {31'b0, out_w}, 32'd0);
        end

        // async reset out of DONE, visible before the next edge
        reset_n = 1'b0;
        #1;
        check("async_rst_done", {31'b0, done_w}, 32'd0);
        tick();
        reset_n = 1'b1;
        enable  = 1'b0;
        tick();
        check("idle_hold_out", {31'b0, out_w}, 32'd0);

        // restart with 80000001
        in_w   = 32'h80000001;
        enable = 1'b1;
        tick();
        check("restart_first", {31'b0, out_w}, 32'd1);
        repeat (31) tick();
        check("restart_bit31", {31'b0, out_w}, 32'd1);
        tick();
        check("restart_done", {31'b0, done_w}, 32'd1);

        // pause for 3 cycles after bit 5
        reset_pulse();
        in_w   = 32'hFFFFFFFF;
        enable = 1'b1;
        tick();
        repeat (5) tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_out", {31'b0, out_w}, 32'd1);
            check("pause_done", {31'b0, done_w}, 32'd0);
        end
        enable = 1'b1;
        repeat (26) tick();
        check("pause_last_bit", {31'b0, out_w}, 32'd1);
        check("pause_done_late", {31'b0, done_w}, 32'd0);
        tick();
        check("pause_done_edge", {31'b0, done_w}, 32'd1);

        // reset mid-transfer, then reset held with enable high
        reset_pulse();
        in_w   = 32'hFFFFFFFF;
        enable = 1'b1;
        repeat (3) tick();
        check("mid_out_before", {31'b0, out_w}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_out", {31'b0, out_w}, 32'd0);
        check("mid_rst_done", {31'b0, done_w}, 32'd0);
        tick();
        check("rst_wins_out", {31'b0, out_w}, 32'd0);
        reset_n = 1'b1;
        repeat (40) tick();

        // in-flight change of `in`
        reset_pulse();
        in_w   = 32'hA5A5A5A5;
        enable = 1'b1;
        tick();
        in_w = 32'h0;
        check("inflight_b0", {31'b0, out_w}, 32'd1);
        tick();
        check("inflight_b1", {31'b0, out_w}, 32'd0);
        tick();
        check("inflight_b2", {31'b0, out_w}, 32'd1);
        repeat (32) tick();

        // bit order pin with 80000000
        reset_pulse();
        in_w   = 32'h80000000;
        enable = 1'b1;
        tick();
`ifdef BYTE_TX_MSB_FIRST_EN
        check("order_first", {31'b0, out_w}, 32'd1);
`else
        check("order_first", {31'b0, out_w}, 32'd0);
`endif
        repeat (33) tick();

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            reset_pulse();
            for (int c = 0; c < 60; c++) begin
                enable = ($urandom_range(0, 3) != 0);
                in_w   = $urandom;
                if ($urandom_range(0, 149) == 0) begin
                    #1 reset_n = 1'b0;
                    #1;
                    check("rand_rst_out", {31'b0, out_w}, 32'd0);
                    check("rand_rst_done", {31'b0, done_w}, 32'd0);
                    tick();
                    reset_n = 1'b1;
                end else begin
                    tick();
                end
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
